// File: rtl/eth_ta_pkg.sv
// Shared constants and elaboration helpers for the Ethernet Avalon-ST timing adapter.
package eth_ta_pkg;

    localparam int unsigned MAX_READY_LATENCY = 4;
    localparam int unsigned OVF_CNT_W         = 16;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Power-of-2 depth with room for every in-flight beat plus one spare entry.
    function automatic bit params_legal(input int unsigned depth,
                                        input int unsigned latency,
                                        input int unsigned use_in_ready);
        bit pow2;
        pow2 = (depth != 0) && ((depth & (depth - 1)) == 0);
        return pow2 && (latency <= MAX_READY_LATENCY) && (depth >= latency + 2)
               && (use_in_ready <= 1);
    endfunction

endpackage

// File: rtl/eth_ta_fifo_mem.sv
// Show-ahead FIFO storage: data array, read/write pointers and occupancy count.
module eth_ta_fifo_mem
    import eth_ta_pkg::*;
#(
    parameter int unsigned DATA_W = 72,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [DATA_W-1:0]           i_wdata,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [ptr_width(DEPTH):0]   o_count
);

    localparam int unsigned AW = ptr_width(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // Pointers wrap by natural binary rollover since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/eth_st_timing_adapter_fifo.sv
// Avalon-ST timing adapter: ready-latency-N (or unbackpressurable) source to ready-latency-0 sink.
// Define ETH_TA_OVF_CNT_EN to build the 16-bit saturating dropped-beat counter on ovf_count.
module eth_st_timing_adapter_fifo
    import eth_ta_pkg::*;
#(
    parameter int unsigned DATA_W           = 72,
    parameter int unsigned DEPTH            = 8,
    parameter int unsigned IN_READY_LATENCY = 0,
    parameter int unsigned USE_IN_READY     = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ptr_width(DEPTH):0]   fill_level,
    output logic                        overflow,
    input  logic                        ovf_clear,
    output logic [OVF_CNT_W-1:0]        ovf_count
);

    localparam int unsigned CW = ptr_width(DEPTH) + 1;

    generate
        if (!params_legal(DEPTH, IN_READY_LATENCY, USE_IN_READY)) begin : g_bad_params
            $error("eth_st_timing_adapter_fifo: illegal DEPTH/IN_READY_LATENCY/USE_IN_READY");
        end
    endgenerate

    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_next;
    logic [DATA_W-1:0] w_rdata;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_out_valid;
    logic              r_in_ready;
    logic              r_overflow;

    // Writes ignore in_ready: the upstream latency contract is what guarantees headroom.
    always_comb begin
        w_out_valid  = (w_count != '0);
        w_pop        = w_out_valid && out_ready;
        w_push       = in_valid && ((w_count < CW'(DEPTH)) || w_pop);
        w_drop       = in_valid && !w_push;
        w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    end

    eth_ta_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (in_data),
        .o_rdata (w_rdata),
        .o_count (w_count)
    );

    generate
        if (USE_IN_READY != 0) begin : g_ready_bp
            logic [CW-1:0] w_room;
            assign w_room = CW'(DEPTH) - w_count_next;

            // Deassert while fewer free slots remain than beats that may still be in flight.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_in_ready <= 1'b0;
                end else begin
                    r_in_ready <= (w_room > CW'(IN_READY_LATENCY));
                end
            end
        end else begin : g_ready_const
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_in_ready <= 1'b0;
                end else begin
                    r_in_ready <= 1'b1;
                end
            end
        end
    endgenerate

    // A drop wins over a coincident clear so no loss goes unreported.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clear) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef ETH_TA_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] r_ovf_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_count <= '0;
        end else if (ovf_clear) begin
            r_ovf_count <= OVF_CNT_W'(w_drop);
        end else if (w_drop && (r_ovf_count != '1)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign ovf_count = r_ovf_count;
`else
    assign ovf_count = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && w_drop) begin
            $display("%m: input beat dropped, FIFO full at %0t", $time);
        end
    end
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = w_rdata;
    assign fill_level = w_count;
    assign overflow   = r_overflow;

endmodule

// File: doc/eth_st_timing_adapter_fifo.md
Name: eth_st_timing_adapter_fifo

Overview:
- Parametrised Avalon-ST timing adapter for the 10G Ethernet loopback path.
- Accepts a source with ready latency IN_READY_LATENCY (0..4), or a source that cannot be backpressured at all, and drives a ready-latency-0 sink.
- A small show-ahead FIFO absorbs the latency mismatch.
- Flags any beats dropped when the upstream is not, or cannot be, backpressured.

Parameters:
- DATA_W, 72, payload width in bits.
- DEPTH, 8, FIFO entries; power of 2; must be >= IN_READY_LATENCY+2 (elaboration error otherwise).
- IN_READY_LATENCY, 0, upstream ready latency in cycles; legal range 0..4.
- USE_IN_READY, 1, 1 = upstream honours in_ready; 0 = upstream cannot be backpressured, in_ready is tied to 1.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  upstream payload.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  backpressure to upstream, registered.
- out_data  out  DATA_W  downstream payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream ready, latency 0.
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a beat was dropped.
- ovf_clear  in  1  synchronous clear of overflow.
- ovf_count  out  16  count of dropped beats (optional feature only).

Behaviour:
- Reset values: out_valid=0, in_ready=0, overflow=0, fill_level=0, ovf_count=0, read and write pointers=0. out_data is don't-care while out_valid=0.
- Reset mid-operation: FIFO contents are discarded immediately (asynchronous). in_ready rises on the first clk edge after reset deasserts.
- Write:
  - push = in_valid && (count<DEPTH || pop).
  - in_valid with count==DEPTH and no pop: beat dropped, overflow<=1, ovf_count increments.
  - The write is independent of the current in_ready value; the upstream latency contract guarantees headroom.
- Read:
  - Show-ahead: out_valid = (count!=0); out_data = mem[rd_ptr].
  - pop = out_valid && out_ready.
  - out_data is stable while out_valid && !out_ready.
- Latency: a beat pushed in cycle N appears on out_valid in cycle N+1. There is no same-cycle bypass, including when the FIFO is empty.
- Count update:
  - count_next = count + push - pop.
  - Simultaneous push and pop at full is legal; count stays at DEPTH.
  - Simultaneous push and pop at empty cannot occur, because pop needs out_valid.
- in_ready:
  - USE_IN_READY=1: register updated every cycle, in_ready <= (DEPTH - count_next) > IN_READY_LATENCY.
  - This guarantees room for all beats the upstream sends up to IN_READY_LATENCY cycles after in_ready falls. A compliant source never overflows.
  - USE_IN_READY=0: in_ready=1 constant after reset. Overflow is the only protection.
- Pointers: wrap modulo DEPTH through natural binary rollover. fill_level = count.
- overflow: sticky.
  - Cleared by ovf_clear.
  - A drop and ovf_clear in the same cycle leaves overflow=1.
  - Simulation-only $display on each drop.

Optional Feature:
- Macro: ETH_TA_OVF_CNT_EN.
- Defined: ovf_count is a 16-bit saturating counter.
  - Increments once per dropped beat and holds at 0xFFFF.
  - Cleared by ovf_clear; a drop in the same cycle as ovf_clear gives ovf_count=1.
- Undefined: ovf_count is tied to 0 and no counter logic is built.

Decomposition:
- Package eth_ta_pkg holds:
  - the MAX_READY_LATENCY=4 constant;
  - the OVF_CNT_W=16 constant;
  - the clog2-based pointer/count width function;
  - the parameter legality check function.
- Sub-module eth_ta_fifo_mem holds the storage array, the rd/wr pointers and the count.
  - Inputs: push, pop, wdata.
  - Outputs: rdata, count.
  - The top holds the ready, overflow and counter logic.

Test Plan:
- L=2, DEPTH=8, out_ready=0, source sends continuously while honouring latency -> in_ready falls at fill 5, fill_level peaks at 8, overflow stays 0.
- Empty FIFO, single beat 0xAB in cycle N with out_ready=1 -> out_valid=1 and out_data=0xAB in cycle N+1 only; fill_level returns to 0 at N+2.
- USE_IN_READY=0, DEPTH=4, out_ready=0, 6 beats -> first 4 stored in order, overflow=1. With ETH_TA_OVF_CNT_EN, ovf_count=2.
- Full FIFO with push and pop in the same cycle for 10 cycles -> fill_level stays 8, output order matches input order, no drop.
- Reset asserted mid-burst at fill 5 -> out_valid, in_ready and fill_level are 0 immediately. in_ready=1 one edge after release; the next beat in is the first beat out.
- overflow set, then ovf_clear coincident with a drop -> overflow stays 1. ovf_clear alone next cycle -> overflow 0, ovf_count 0.
